// File: rtl/adpcm.sv
// IMA/DVI 4-bit ADPCM codec: one block that encodes (sel_rx=0) or decodes (sel_rx=1) one sample per transaction.
// Latency: ack pulses 6 cycles after the start cycle (the cycle in which a req toggle is seen in IDLE); outputs are held afterwards.
// Backpressure: none; a req toggle that arrives while busy stays pending and starts the next conversion once the FSM is back in IDLE.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   enable               low = synchronous clear of FSM, ack, predictor and index (tx_* outputs hold)
//   sel_rx               0 = encode rx_pcm -> tx_adpcm, 1 = decode rx_adpcm -> tx_pcm
//   req / ack            toggle request / one-cycle completion pulse
//   rx_pcm, rx_adpcm     sample to encode / code to decode
//   rx_idx               step index for this conversion (used only with ADPCM_IDX_EXT_EN)
//   tx_adpcm, tx_pcm     encoded code / reconstructed predictor
//   tx_idx               updated step index (0..88)
// Build option ADPCM_IDX_EXT_EN: defined -> index loaded from rx_idx every conversion;
// undefined -> rx_idx ignored, the index is an internal register kept between conversions.
module adpcm (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               sel_rx,
    input  logic               req,
    output logic               ack,
    input  logic signed [15:0] rx_pcm,
    input  logic        [3:0]  rx_adpcm,
    input  logic signed [7:0]  rx_idx,
    output logic        [3:0]  tx_adpcm,
    output logic signed [15:0] tx_pcm,
    output logic signed [7:0]  tx_idx
);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_B2, S_B1, S_B0, S_UPDATE, S_ACK} state_t;

    localparam logic [14:0] STEP_TAB [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,    15'd16,    15'd17,
        15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,    15'd34,    15'd37,    15'd41,    15'd45,
        15'd50,    15'd55,    15'd60,    15'd66,    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,
        15'd130,   15'd143,   15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,   15'd724,   15'd796,
        15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,  15'd1552,  15'd1707,  15'd1878,  15'd2066,
        15'd2272,  15'd2499,  15'd2749,  15'd3024,  15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,
        15'd5894,  15'd6484,  15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794, 15'd32767
    };

    function automatic logic signed [7:0] idx_adj(input logic [2:0] d);
        case (d)
            3'd4:    idx_adj = 8'sd2;
            3'd5:    idx_adj = 8'sd4;
            3'd6:    idx_adj = 8'sd6;
            3'd7:    idx_adj = 8'sd8;
            default: idx_adj = -8'sd1;
        endcase
    endfunction

    state_t              state_q;
    logic                req_q;      // registered req; held while busy so a mid-conversion toggle stays pending
    logic                ack_q;
    logic signed [15:0]  pred_q;
    logic        [6:0]   idx_q;
    logic        [14:0]  step_q;
    logic        [16:0]  diff_q;     // remaining |difference| (encode only)
    logic        [16:0]  vp_q;       // accumulated reconstruction delta
    logic                sign_q;
    logic        [2:0]   delta_q;
    logic        [3:0]   tx_adpcm_q;
    logic signed [15:0]  tx_pcm_q;
    logic signed [7:0]   tx_idx_q;

    logic        [6:0]   idx_sel;
    logic        [14:0]  step_d;
    logic        [16:0]  diff_full;
    logic        [16:0]  diff_abs;
    logic        [14:0]  thr;
    logic        [2:0]   bit_mask;
    logic                hit;
    logic signed [17:0]  pred_sum;
    logic signed [15:0]  pred_d;
    logic signed [7:0]   idx_sum;
    logic        [6:0]   idx_d;

`ifdef ADPCM_IDX_EXT_EN
    assign idx_sel = rx_idx[7]        ? 7'd0  :
                     (rx_idx > 8'sd88) ? 7'd88 : rx_idx[6:0];
`else
    logic unused_rx_idx;
    assign unused_rx_idx = ^rx_idx;
    assign idx_sel       = idx_q;
`endif

    assign step_d    = STEP_TAB[idx_sel];
    assign diff_full = {rx_pcm[15], rx_pcm} - {pred_q[15], pred_q};
    assign diff_abs  = diff_full[16] ? (~diff_full + 17'd1) : diff_full;

    // Threshold and code bit for the current successive-approximation step.
    always_comb begin
        thr      = step_q;
        bit_mask = 3'b100;
        case (state_q)
            S_B1: begin thr = step_q >> 1; bit_mask = 3'b010; end
            S_B0: begin thr = step_q >> 2; bit_mask = 3'b001; end
            default: ;
        endcase
        if (sel_rx)
            hit = |(rx_adpcm[2:0] & bit_mask);
        else
            hit = (diff_q >= {2'b00, thr});
    end

    // Predictor and index update, both saturating.
    always_comb begin
        if (sign_q)
            pred_sum = {{2{pred_q[15]}}, pred_q} - $signed({1'b0, vp_q});
        else
            pred_sum = {{2{pred_q[15]}}, pred_q} + $signed({1'b0, vp_q});
        if (pred_sum > 18'sd32767)
            pred_d = 16'sh7FFF;
        else if (pred_sum < -18'sd32768)
            pred_d = 16'sh8000;
        else
            pred_d = pred_sum[15:0];

        idx_sum = $signed({1'b0, idx_q}) + idx_adj(delta_q);
        if (idx_sum[7])
            idx_d = 7'd0;
        else if (idx_sum > 8'sd88)
            idx_d = 7'd88;
        else
            idx_d = idx_sum[6:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            pred_q     <= '0;
            idx_q      <= '0;
            step_q     <= '0;
            diff_q     <= '0;
            vp_q       <= '0;
            sign_q     <= 1'b0;
            delta_q    <= '0;
            tx_adpcm_q <= '0;
            tx_pcm_q   <= '0;
            tx_idx_q   <= '0;
        end else if (!enable) begin
            state_q <= S_IDLE;
            req_q   <= req;
            ack_q   <= 1'b0;
            pred_q  <= '0;
            idx_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_q <= req;
                    if (req != req_q)
                        state_q <= S_STEP;
                end
                S_STEP: begin
                    idx_q   <= idx_sel;
                    step_q  <= step_d;
                    vp_q    <= {5'd0, step_d[14:3]};
                    delta_q <= '0;
                    if (sel_rx) begin
                        sign_q <= rx_adpcm[3];
                        diff_q <= '0;
                    end else begin
                        sign_q <= diff_full[16];
                        diff_q <= diff_abs;
                    end
                    state_q <= S_B2;
                end
                S_B2, S_B1, S_B0: begin
                    if (hit) begin
                        delta_q <= delta_q | bit_mask;
                        vp_q    <= vp_q + {2'b00, thr};
                        if (!sel_rx)
                            diff_q <= diff_q - {2'b00, thr};
                    end
                    case (state_q)
                        S_B2:    state_q <= S_B1;
                        S_B1:    state_q <= S_B0;
                        default: state_q <= S_UPDATE;
                    endcase
                end
                S_UPDATE: begin
                    pred_q   <= pred_d;
                    idx_q    <= idx_d;
                    if (!sel_rx)
                        tx_adpcm_q <= {sign_q, delta_q};
                    tx_pcm_q <= pred_d;
                    tx_idx_q <= {1'b0, idx_d};
                    ack_q    <= 1'b1;
                    state_q  <= S_ACK;
                end
                default: state_q <= S_IDLE;  // S_ACK
            endcase
        end
    end

    assign ack      = ack_q;
    assign tx_adpcm = tx_adpcm_q;
    assign tx_pcm   = tx_pcm_q;
    assign tx_idx   = tx_idx_q;

endmodule

// File: tb/tb_adpcm.sv
module tb_adpcm;

    logic               clk;
    logic               rstn;
    logic               enable;
    logic               sel_rx;
    logic               req;
    logic               ack;
    logic signed [15:0] rx_pcm;
    logic        [3:0]  rx_adpcm;
    logic signed [7:0]  rx_idx;
    logic        [3:0]  tx_adpcm;
    logic signed [15:0] tx_pcm;
    logic signed [7:0]  tx_idx;

    adpcm dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .sel_rx   (sel_rx),
        .req      (req),
        .ack      (ack),
        .rx_pcm   (rx_pcm),
        .rx_adpcm (rx_adpcm),
        .rx_idx   (rx_idx),
        .tx_adpcm (tx_adpcm),
        .tx_pcm   (tx_pcm),
        .tx_idx   (tx_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference codec state: the host-side view (predictor plus fed-back index).
    int mpred = 0;
    int midx  = 0;

    int step_tab [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int idx_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int clamp_idx(input int v);
        if (v < 0)  return 0;
        if (v > 88) return 88;
        return v;
    endfunction

    // Classic C-style IMA encoder, one sample.
    task automatic m_encode(input int s, output int code);
        int step, diff, vp;
        step = step_tab[midx];
        diff = s - mpred;
        code = 0;
        if (diff < 0) begin code = 8; diff = -diff; end
        vp = step / 8;
        if (diff >= step) begin code = code | 4; diff = diff - step; vp = vp + step; end
        step = step / 2;
        if (diff >= step) begin code = code | 2; diff = diff - step; vp = vp + step; end
        step = step / 2;
        if (diff >= step) begin code = code | 1; vp = vp + step; end
        mpred = sat16((code & 8) != 0 ? mpred - vp : mpred + vp);
        midx  = clamp_idx(midx + idx_tab[code & 7]);
    endtask

    // Classic C-style IMA decoder, one code.
    task automatic m_decode(input int code);
        int step, vp;
        step = step_tab[midx];
        vp = step / 8;
        if ((code & 4) != 0) vp = vp + step;
        if ((code & 2) != 0) vp = vp + step / 2;
        if ((code & 1) != 0) vp = vp + step / 4;
        mpred = sat16((code & 8) != 0 ? mpred - vp : mpred + vp);
        midx  = clamp_idx(midx + idx_tab[code & 7]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drop enable for two cycles; DUT and reference both restart from predictor 0, index 0.
    task automatic clr();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        mpred  = 0;
        midx   = 0;
        tick();
    endtask

    // One conversion: host feeds the reference index back as rx_idx, toggles req, waits for ack.
    task automatic txn(input logic sel, input int pcm, input int code);
        int n;
        sel_rx   = sel;
        rx_pcm   = pcm[15:0];
        rx_adpcm = code[3:0];
        rx_idx   = midx[7:0];
        req      = ~req;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack) begin n = k; break; end
        end
        check("ack_latency", n, 6);
        tick();
        check("ack_one_cycle", int'(ack), 0);
    endtask

    typedef struct {
        bit clr;
        bit sel;
        int pcm;
        int code;
        int e_code;
        int e_pcm;
        int e_idx;
    } vec_t;

    vec_t vecs [10];
    int   enc_code [2000];
    int   enc_recon [2000];

    initial begin
        int code, s, prev, acks;
        logic signed [15:0] r16;

        rstn = 1'b0; enable = 1'b0; sel_rx = 1'b0; req = 1'b0;
        rx_pcm = '0; rx_adpcm = '0; rx_idx = '0;

        vecs[0] = '{1, 0,   1000, 0,  7,  11, 8};
        vecs[1] = '{1, 0,  -1000, 0, 15, -11, 8};
        vecs[2] = '{0, 0,      0, 0,  2,  -1, 7};
        vecs[3] = '{1, 1,      0, 7,  2,  11, 8};   // decode leaves tx_adpcm alone
        vecs[4] = '{1, 1,      0, 0,  2,   0, 0};   // index low clamp
        vecs[5] = '{0, 1,      0, 8,  2,   0, 0};
        vecs[6] = '{0, 1,      0, 7,  2,  11, 8};
        vecs[7] = '{0, 0,     11, 0,  0,  13, 7};
        vecs[8] = '{1, 0,  32767, 0,  7,  11, 8};
        vecs[9] = '{0, 0, -32768, 0, 15, -19, 16};

        repeat (3) tick();
        check("rst_ack", int'(ack), 0);
        check("rst_tx_adpcm", int'(tx_adpcm), 0);
        check("rst_tx_pcm", int'(tx_pcm), 0);
        check("rst_tx_idx", int'(tx_idx), 0);
        rstn = 1'b1;
        tick();
        enable = 1'b1;
        tick();

        // Directed vectors with hand-computed expectations.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].clr) clr();
            if (vecs[i].sel) m_decode(vecs[i].code);
            else             m_encode(vecs[i].pcm, code);
            txn(vecs[i].sel, vecs[i].pcm, vecs[i].code);
            check($sformatf("vec%0d_tx_adpcm", i), int'(tx_adpcm), vecs[i].e_code);
            check($sformatf("vec%0d_tx_pcm", i), int'(tx_pcm), vecs[i].e_pcm);
            check($sformatf("vec%0d_tx_idx", i), int'(tx_idx), vecs[i].e_idx);
        end

        // Full-scale alternation: predictor saturates both ways, index climbs and clamps at 88.
        clr();
        for (int i = 0; i < 24; i++) begin
            s = (i % 2 == 0) ? 32767 : -32768;
            m_encode(s, code);
            txn(1'b0, s, 0);
            check("swing_tx_adpcm", int'(tx_adpcm), code);
            check("swing_tx_pcm", int'(tx_pcm), mpred);
            check("swing_tx_idx", int'(tx_idx), midx);
        end
        check("swing_idx_clamped", int'(tx_idx), 88);

        // Repeated positive full scale: predictor pinned at the top rail.
        for (int i = 0; i < 12; i++) begin
            m_encode(32767, code);
            txn(1'b0, 32767, 0);
            check("rail_tx_pcm", int'(tx_pcm), mpred);
            check("rail_tx_idx", int'(tx_idx), midx);
        end

        // Enable dropped mid-conversion, then a req toggle while disabled.
        clr();
        m_encode(1000, code);
        txn(1'b0, 1000, 0);
        check("abort_pre_pcm", int'(tx_pcm), 11);
        req = ~req;
        rx_pcm = 16'sd5000;
        repeat (3) tick();
        enable = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ack) acks++;
            if (k == 3) req = ~req;
        end
        check("abort_no_ack", acks, 0);
        check("abort_tx_pcm_held", int'(tx_pcm), 11);
        check("abort_tx_idx_held", int'(tx_idx), 8);
        enable = 1'b1;
        mpred = 0;
        midx  = 0;
        acks  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ack) acks++;
        end
        check("no_start_after_enable", acks, 0);
        m_encode(1000, code);
        txn(1'b0, 1000, 0);
        check("restart_tx_adpcm", int'(tx_adpcm), 7);
        check("restart_tx_pcm", int'(tx_pcm), 11);
        check("restart_tx_idx", int'(tx_idx), 8);

        // Random waveform: encode, then decode the codes back from a fresh state.
        clr();
        prev = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r16 = 16'($urandom);
                s = r16;
            end else begin
                s = sat16(prev + int'($urandom_range(0, 4000)) - 2000);
            end
            prev = s;
            m_encode(s, code);
            enc_code[i]  = code;
            enc_recon[i] = mpred;
            txn(1'b0, s, 0);
            check("enc_tx_adpcm", int'(tx_adpcm), code);
            check("enc_tx_pcm", int'(tx_pcm), mpred);
            check("enc_tx_idx", int'(tx_idx), midx);
        end
        clr();
        for (int i = 0; i < 2000; i++) begin
            m_decode(enc_code[i]);
            txn(1'b1, 0, enc_code[i]);
            check("dec_tx_pcm", int'(tx_pcm), enc_recon[i]);
            check("dec_tx_idx", int'(tx_idx), midx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
